// File: rtl/marquee_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : marquee_pkg
//  Purpose  : Shared constants for the "NTHUEE" seven-segment marquee:
//             active-low segment codes (bit7 = dp, 1 = off), the message
//             length, the sequencer state encoding, the message ROM lookup
//             and modulo-6 pointer arithmetic helpers.
//  Revision : 1.0  initial release
// ============================================================================
package marquee_pkg;

    // Active-low segment patterns; dp is always off.
    localparam logic [7:0] SS_N     = 8'hAB;
    localparam logic [7:0] SS_T     = 8'h87;
    localparam logic [7:0] SS_H     = 8'h89;
    localparam logic [7:0] SS_U     = 8'hC1;
    localparam logic [7:0] SS_E     = 8'h86;
    localparam logic [7:0] SS_BLANK = 8'hFF;

    localparam int         MSG_LEN  = 6;
    localparam logic [2:0] PTR_LAST = 3'(MSG_LEN - 1);

    typedef enum logic [1:0] {
        ST_SCROLL = 2'b00,
        ST_HOLD   = 2'b01,
        ST_BLINK  = 2'b10
    } state_t;

    // Message "nTHUEE", index 0..5. Out-of-range indices read blank.
    function automatic logic [7:0] msg_rom(input logic [2:0] idx);
        logic [7:0] code;
        case (idx)
            3'd0:    code = SS_N;
            3'd1:    code = SS_T;
            3'd2:    code = SS_H;
            3'd3:    code = SS_U;
            3'd4:    code = SS_E;
            3'd5:    code = SS_E;
            default: code = SS_BLANK;
        endcase
        return code;
    endfunction

    // (base + off) mod MSG_LEN for base, off in 0..MSG_LEN-1.
    function automatic logic [2:0] ptr_add(input logic [2:0] base,
                                           input logic [2:0] off);
        logic [3:0] sum;
        sum = {1'b0, base} + {1'b0, off};
        if (sum >= 4'(MSG_LEN)) begin
            sum = sum - 4'(MSG_LEN);
        end
        return sum[2:0];
    endfunction

    // One scroll step: left (+1) when dir = 0, right (-1) when dir = 1.
    function automatic logic [2:0] ptr_step(input logic [2:0] cur,
                                            input logic       dir_right);
        logic [2:0] nxt;
        if (dir_right) begin
            nxt = (cur == 3'd0) ? PTR_LAST : cur - 3'd1;
        end else begin
            nxt = (cur == PTR_LAST) ? 3'd0 : cur + 3'd1;
        end
        return nxt;
    endfunction

endpackage : marquee_pkg
`default_nettype wire

// File: rtl/marquee_window.sv
`default_nettype none
// ============================================================================
//  Module   : marquee_window
//  Purpose  : Combinational 4-digit view into the message ring. digit3 shows
//             the character at i_ptr, each digit to the right shows the next
//             character. i_blank forces all four digits dark.
//  Ports    : i_ptr    [2:0]  message index shown on the leftmost digit
//             i_blank         1 = all digits off
//             o_digit3..o_digit0 [7:0]  active-low segment patterns
//  Revision : 1.0  initial release
// ============================================================================
module marquee_window
    import marquee_pkg::*;
(
    input  logic [2:0] i_ptr,
    input  logic       i_blank,
    output logic [7:0] o_digit3,
    output logic [7:0] o_digit2,
    output logic [7:0] o_digit1,
    output logic [7:0] o_digit0
);

    logic [7:0] w_digit [4];

    // Digit K shows message index (ptr + 3 - K) mod 6.
    for (genvar k = 0; k < 4; k++) begin : g_digit
        assign w_digit[k] = i_blank ? SS_BLANK
                                    : msg_rom(ptr_add(i_ptr, 3'(3 - k)));
    end

    assign o_digit3 = w_digit[3];
    assign o_digit2 = w_digit[2];
    assign o_digit1 = w_digit[1];
    assign o_digit0 = w_digit[0];

endmodule : marquee_window
`default_nettype wire

// File: rtl/marquee_scroll_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : marquee_scroll_ctrl
//  Purpose  : SCROLL -> HOLD -> BLINK sequencer for the "NTHUEE" marquee on
//             the 1 Hz tick clock. Owns the scroll pointer, the hold and
//             blink counters and the blank flag; digit patterns are derived
//             combinationally from those registers.
//  Ports    : clk_1hz            1 Hz tick clock (posedge)
//             rst                asynchronous, active-low reset
//             run                1 = advance each edge, 0 = freeze
//             dir                0 = scroll left (+1), 1 = scroll right (-1)
//             restart            synchronous return to ptr 0 / SCROLL
//             digit3..digit0     active-low segment patterns (digit3 left)
//             ptr    [2:0]       message index shown on digit3
//             state  [1:0]       00 SCROLL, 01 HOLD, 10 BLINK
//             wrap               one-cycle pulse when scrolling lands on 0
//  Revision : 1.0  initial release
// ============================================================================
module marquee_scroll_ctrl
    import marquee_pkg::*;
#(
    parameter int HOLD_SEC  = 2,   // 1..15
    parameter int BLINK_CNT = 2    // 0..7, 0 skips BLINK
) (
    input  logic       clk_1hz,
    input  logic       rst,
    input  logic       run,
    input  logic       dir,
    input  logic       restart,
    output logic [7:0] digit3,
    output logic [7:0] digit2,
    output logic [7:0] digit1,
    output logic [7:0] digit0,
    output logic [2:0] ptr,
    output logic [1:0] state,
    output logic       wrap
);

    localparam logic [3:0] C_HOLD_TARGET  = 4'(HOLD_SEC);
    localparam logic [3:0] C_BLINK_TARGET = 4'(2 * BLINK_CNT);
    localparam bit         C_SKIP_BLINK   = (BLINK_CNT == 0);

    state_t     r_state;
    logic [2:0] r_ptr;
    logic [3:0] r_hold_cnt;
    logic [3:0] r_blink_cnt;
    logic       r_blank;
    logic       r_wrap;

    logic [2:0] w_ptr_next;
    logic [3:0] w_hold_inc;
    logic [3:0] w_blink_inc;

    assign w_ptr_next  = ptr_step(r_ptr, dir);
    assign w_hold_inc  = r_hold_cnt + 4'd1;
    assign w_blink_inc = r_blink_cnt + 4'd1;

    always_ff @(posedge clk_1hz or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_SCROLL;
            r_ptr       <= 3'd0;
            r_hold_cnt  <= 4'd0;
            r_blink_cnt <= 4'd0;
            r_blank     <= 1'b0;
            r_wrap      <= 1'b0;
        end else if (restart) begin
            r_state     <= ST_SCROLL;
            r_ptr       <= 3'd0;
            r_hold_cnt  <= 4'd0;
            r_blink_cnt <= 4'd0;
            r_blank     <= 1'b0;
            r_wrap      <= 1'b0;
        end else if (!run) begin
            // Frozen: only the wrap pulse is allowed to drop.
            r_wrap <= 1'b0;
        end else begin
            r_wrap <= 1'b0;
            case (r_state)
                ST_SCROLL: begin
                    r_ptr <= w_ptr_next;
                    // Landing on 0 completes a revolution; leaving 0 to the
                    // right (0 -> 5) does not.
                    if (w_ptr_next == 3'd0) begin
                        r_wrap     <= 1'b1;
                        r_state    <= ST_HOLD;
                        r_hold_cnt <= 4'd0;
                    end
                end
                ST_HOLD: begin
                    if (w_hold_inc == C_HOLD_TARGET) begin
                        r_hold_cnt <= 4'd0;
                        r_state    <= C_SKIP_BLINK ? ST_SCROLL : ST_BLINK;
                    end else begin
                        r_hold_cnt <= w_hold_inc;
                    end
                end
                ST_BLINK: begin
                    // The final edge of an even toggle count lands on
                    // visible; forcing 0 here keeps that explicit.
                    if (w_blink_inc == C_BLINK_TARGET) begin
                        r_blink_cnt <= 4'd0;
                        r_blank     <= 1'b0;
                        r_state     <= ST_SCROLL;
                    end else begin
                        r_blink_cnt <= w_blink_inc;
                        r_blank     <= ~r_blank;
                    end
                end
                default: begin
                    r_state <= ST_SCROLL;
                end
            endcase
        end
    end

    marquee_window u_window (
        .i_ptr    (r_ptr),
        .i_blank  (r_blank),
        .o_digit3 (digit3),
        .o_digit2 (digit2),
        .o_digit1 (digit1),
        .o_digit0 (digit0)
    );

    assign ptr   = r_ptr;
    assign state = r_state;
    assign wrap  = r_wrap;

endmodule : marquee_scroll_ctrl
`default_nettype wire
